// File: rtl/sm_pkg.sv
// sm_pkg: shared constants and FSM encoding for the sign-magnitude multiply/add path
package sm_pkg;
  localparam int DEF_MAG_W = 10;
  localparam int SM_W = 2*DEF_MAG_W+1;
  localparam int SIGN_BIT = SM_W-1;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/sm_shift_add_dp.sv
// sm_shift_add_dp: accumulator, shifting multiplicand and multiplier for the shift-add loop
module sm_shift_add_dp
  import sm_pkg::*;
#(parameter int MAG_W = DEF_MAG_W) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [MAG_W-1:0]   a_mag,
  input  logic [MAG_W-1:0]   b_mag,
  output logic [2*MAG_W-1:0] acc_next
);
  logic [2*MAG_W-1:0] acc, mcand;
  logic [MAG_W-1:0]   mplier;
  assign acc_next = mplier[0] ? acc + mcand : acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{MAG_W{1'b0}}, a_mag};
      mplier <= b_mag;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
endmodule

// File: rtl/sm_seq_multiplier.sv
// sm_seq_multiplier: iterative sign-magnitude multiplier with valid/ready on both sides
module sm_seq_multiplier
  import sm_pkg::*;
#(parameter int MAG_W = DEF_MAG_W) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W:0]   a,
  input  logic [MAG_W:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*MAG_W:0] product,
  output logic             busy
);
  localparam int CW = $clog2(MAG_W+1);
  state_t state, state_nx;
  logic [CW-1:0] count;
  logic sign, accept, last, zero;
  logic [2*MAG_W-1:0] acc_next;
  assign accept = state == IDLE && in_valid;
  assign last   = state == CALC && count == CW'(MAG_W-1);
  // -0 operands count as zero so the product never carries a negative sign on zero
  assign zero   = a[MAG_W-1:0] == '0 || b[MAG_W-1:0] == '0;
  sm_shift_add_dp #(.MAG_W(MAG_W)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (state == CALC),
    .a_mag    (a[MAG_W-1:0]),
    .b_mag    (b[MAG_W-1:0]),
    .acc_next (acc_next)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (in_valid ? (zero ? DONE : CALC) : IDLE) :
               state == CALC ? (last ? DONE : CALC) :
               state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state == CALC || state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count   <= '0;
      sign    <= 1'b0;
      product <= '0;
    end else begin
      if (accept) begin
        count <= '0;
        sign  <= a[MAG_W] ^ b[MAG_W];
        if (zero) product <= '0;
      end else if (state == CALC) count <= count + 1'b1;
      if (last) product <= {sign, acc_next};
    end
endmodule

// File: tb/tb_sm_seq_multiplier.sv
// tb_sm_seq_multiplier: scoreboard bench for the sign-magnitude sequential multiplier
module tb_sm_seq_multiplier;
  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [10:0] a, b;
  logic [20:0] product;
  logic [20:0] q[$];
  int checks = 0, passed = 0, accepts = 0;

  sm_seq_multiplier dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [20:0] model(input logic [10:0] x, input logic [10:0] y);
    logic [19:0] m;
    m = x[9:0] * y[9:0];
    return {(m != 0) & (x[10] ^ y[10]), m};
  endfunction

  function automatic logic [20:0] pop();
    if (q.size() == 0) return 'x;
    return q.pop_front();
  endfunction

  task automatic send(input logic [10:0] x, input logic [10:0] y);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
      return;
    end
    a = x;
    b = y;
    in_valid = 1;
    @(posedge clk);
    q.push_back(model(x, y));
    accepts++;
    #1 in_valid = 0;
  endtask

  task automatic wait_valid(output int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    lat = n;
    if (!out_valid) begin
      checks++;
      $display("FAIL wait_valid_timeout out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 0; a = '0; b = '0;
    #12;
    checks++;
    if ({product, out_valid, busy} !== 23'd0)
      $display("FAIL reset_outputs got product=%h valid=%b busy=%b required 0/0/0", product, out_valid, busy);
    else passed++;
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b required 1", in_ready);
    else passed++;
  endtask

  task automatic test_basic();
    int lat;
    logic [20:0] exp;
    out_ready = 1;
    send(11'h003, 11'h405);
    wait_valid(lat);
    checks++;
    if (lat !== 11) $display("FAIL basic_latency got %0d required 11", lat);
    else passed++;
    exp = pop();
    checks++;
    if (product !== exp || product !== 21'h10000F)
      $display("FAIL basic_product got %h required %h", product, exp);
    else passed++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL basic_one_cycle out_valid=%b required 0", out_valid);
    else passed++;
  endtask

  task automatic test_max();
    int lat;
    logic [20:0] exp;
    out_ready = 1;
    send(11'h7FF, 11'h7FF);
    wait_valid(lat);
    exp = pop();
    checks++;
    if (product !== exp || product !== 21'h0FF801)
      $display("FAIL max_product got %h required %h", product, exp);
    else passed++;
    checks++;
    if (lat !== 11) $display("FAIL max_latency got %0d required 11", lat);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat;
    logic [20:0] exp;
    out_ready = 1;
    send(11'h400, 11'h407);
    wait_valid(lat);
    checks++;
    if (lat !== 1) $display("FAIL zero_latency got %0d required 1", lat);
    else passed++;
    exp = pop();
    checks++;
    if (product !== exp || product !== 21'h000000)
      $display("FAIL zero_product got %h required %h", product, exp);
    else passed++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL zero_one_cycle out_valid=%b required 0", out_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [20:0] exp;
    out_ready = 0;
    send(11'h002, 11'h002);
    wait_valid(lat);
    exp = pop();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 11'h00F;
      b = 11'h00F;
      @(negedge clk);
      checks++;
      if (product !== exp || product !== 21'h000004 || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL stall_hold[%0d] got product=%h valid=%b in_ready=%b required %h/1/0",
                 i, product, out_valid, in_ready, exp);
      else passed++;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_consume got valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    else passed++;
    send(11'h003, 11'h004);
    wait_valid(lat);
    exp = pop();
    checks++;
    if (product !== exp || q.size() != 0)
      $display("FAIL stall_next got %h required %h (queue %0d)", product, exp, q.size());
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [20:0] exp;
    out_ready = 1;
    send(11'd100, 11'd100);
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if ({product, out_valid, busy} !== 23'd0)
      $display("FAIL midreset_outputs got product=%h valid=%b busy=%b required 0/0/0", product, out_valid, busy);
    else passed++;
    q.delete();
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL midreset_idle got in_ready=%b valid=%b required 1/0", in_ready, out_valid);
    else passed++;
    send(11'h001, 11'h401);
    wait_valid(lat);
    exp = pop();
    checks++;
    if (product !== exp || product !== 21'h100001)
      $display("FAIL midreset_next got %h required %h", product, exp);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int got = 0, start = accepts;
    fork
      for (int i = 0; i < 8; i++) begin
        logic [10:0] x, y;
        x[9:0] = ($urandom % 4 == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        y[9:0] = ($urandom % 4 == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        x[10] = 1'($urandom);
        y[10] = 1'($urandom);
        send(x, y);
      end
      begin
        int n = 0;
        logic [20:0] exp;
        while (got < 8 && n < 3000) begin
          @(negedge clk);
          n++;
          out_ready = 1'($urandom);
          if (out_valid && out_ready) begin
            exp = pop();
            checks++;
            if (product !== exp) $display("FAIL stream[%0d] got %h required %h", got, product, exp);
            else passed++;
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 8 || accepts - start != 8 || q.size() != 0)
      $display("FAIL stream_count got results=%0d accepts=%0d queued=%0d required 8/8/0",
               got, accepts - start, q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
